// File: rtl/image_tx.sv
// image_tx
// Serializing transmitter for one binarized image. Upstream hands over the
// whole image in parallel through a four-phase load request/acknowledge
// handshake. The block then waits for the receiver to become ready, issues a
// single-cycle start strobe and streams the image LSB first, one bit per
// clock, with no gaps.
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_xrst      asynchronous reset, active-high
//   i_load_req  upstream request, i_image_in is valid
//   o_load_ack  image captured, transfer in progress
//   i_image_in  parallel image, bit 0 is sent first
//   i_rcv_req   receiver ready to accept an image
//   o_rcv_ack   start strobe to the receiver, high exactly one cycle
//   o_tx_bit    serial data to the receiver
//   o_busy      high whenever the block is not idle
module image_tx #(
  parameter int INPUT_NUM = 784,
  parameter int CNT_W     = 10
) (
  input  logic                 i_clk,
  input  logic                 i_xrst,
  input  logic                 i_load_req,
  output logic                 o_load_ack,
  input  logic [INPUT_NUM-1:0] i_image_in,
  input  logic                 i_rcv_req,
  output logic                 o_rcv_ack,
  output logic                 o_tx_bit,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_ACK  = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_NUM - 1);

  state_t               r_state;
  state_t               w_stateNext;
  logic [INPUT_NUM-1:0] r_sreg;
  logic [INPUT_NUM-1:0] w_sregNext;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cntNext;

  // State, shift register and bit counter. Reset aborts any transfer in
  // flight and clears the image so nothing stale can leak out later.
  always_ff @(posedge i_clk or posedge i_xrst) begin
    if (i_xrst) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_sreg  <= w_sregNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state and output decode. Outputs depend only on registered state
  // and the shift register LSB, so no input reaches an output
  // combinationally. The ACK cycle sits between ARM and SEND so that bit 0
  // appears exactly one cycle after the start strobe, which is when the
  // receiver stores its first bit.
  always_comb begin
    w_stateNext = r_state;
    w_sregNext  = r_sreg;
    w_cntNext   = r_cnt;
    o_load_ack  = 1'b0;
    o_rcv_ack   = 1'b0;
    o_tx_bit    = 1'b0;
    o_busy      = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (i_load_req) begin
          w_sregNext  = i_image_in;
          w_cntNext   = '0;
          w_stateNext = ST_ARM;
        end
      end

      ST_ARM: begin
        o_load_ack = 1'b1;
        if (i_rcv_req) begin
          w_stateNext = ST_ACK;
        end
      end

      ST_ACK: begin
        o_load_ack  = 1'b1;
        o_rcv_ack   = 1'b1;
        w_cntNext   = '0;
        w_stateNext = ST_SEND;
      end

      ST_SEND: begin
        o_load_ack = 1'b1;
        o_tx_bit   = r_sreg[0];
        w_sregNext = {1'b0, r_sreg[INPUT_NUM-1:1]};
        if (r_cnt == LAST_CNT) begin
          w_cntNext   = '0;
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_image_tx.sv
// tb_image_tx
// Self-checking bench for image_tx. A driver issues image loads and receiver
// requests; every captured image is pushed into an expected queue. A
// separate receiver monitor waits for the start strobe, collects the next
// INPUT_NUM serial bits into a word and compares it against the queue head.
module tb_image_tx;

  localparam int N  = 784;
  localparam int CW = 10;

  logic         clk      = 1'b0;
  logic         xrst     = 1'b0;
  logic         load_req = 1'b0;
  logic         rcv_req  = 1'b0;
  logic [N-1:0] image_in = '0;
  logic         load_ack;
  logic         rcv_ack;
  logic         tx_bit;
  logic         busy;

  int           checksTotal  = 0;
  int           checksPassed = 0;
  logic [N-1:0] expQ[$];
  bit           resetAbort   = 1'b0;

  image_tx #(
    .INPUT_NUM (N),
    .CNT_W     (CW)
  ) dut (
    .i_clk      (clk),
    .i_xrst     (xrst),
    .i_load_req (load_req),
    .o_load_ack (load_ack),
    .i_image_in (image_in),
    .i_rcv_req  (rcv_req),
    .o_rcv_ack  (rcv_ack),
    .o_tx_bit   (tx_bit),
    .o_busy     (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single scalar comparison with pass/total bookkeeping.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Random image assembled from 32-bit chunks.
  function automatic logic [N-1:0] randImg();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r = (r << 32) | N'($urandom());
    return r;
  endfunction

  // One complete transfer seen from the upstream/receiver side. With
  // preloaded set, load_req and image_in are already driven. With keepLoad
  // set, load_req stays high and image_in switches to nextImg once the
  // current image is on its way, giving a back-to-back capture.
  task automatic applyStimulus(input logic [N-1:0] img, input int armWait,
                               input bit preloaded, input bit keepLoad,
                               input logic [N-1:0] nextImg);
    int waited;
    bit armOk;
    if (!preloaded) begin
      @(negedge clk);
      image_in = img;
      load_req = 1'b1;
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!load_ack && waited < 6);
    checkOutput("captureLatency", waited, 1);
    expQ.push_back(img);
    if (!keepLoad) load_req = 1'b0;
    if (armWait > 0) begin
      rcv_req = 1'b0;
      armOk   = 1'b1;
      repeat (armWait) begin
        @(negedge clk);
        armOk = armOk && load_ack && busy && !rcv_ack && !tx_bit;
      end
      checkOutput("armHold", armOk, 1);
    end
    rcv_req = 1'b1;
    @(negedge clk);
    checkOutput("ackNext", rcv_ack, 1);
    rcv_req = 1'b0;
    if (keepLoad) image_in = nextImg;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (busy && waited < N + 50);
    checkOutput("xferLength", waited, N + 1);
  endtask

  // Receiver model: WAIT for the strobe, receive N bits, then check that the
  // line is quiet on the cycle after the last bit.
  initial begin : monitor
    logic [N-1:0] word;
    logic [N-1:0] exp;
    int           idx;
    bit           collecting;
    bit           postPending;
    bit           holdOk;
    word = '0; exp = '0; idx = 0;
    collecting = 1'b0; postPending = 1'b0; holdOk = 1'b1;
    forever begin
      @(negedge clk);
      if (resetAbort) begin
        if (collecting && expQ.size() > 0) void'(expQ.pop_front());
        collecting  = 1'b0;
        postPending = 1'b0;
        resetAbort  = 1'b0;
      end else if (!xrst) begin
        if (postPending) begin
          checkOutput("afterLast", {28'd0, tx_bit, busy, load_ack, rcv_ack}, 0);
          postPending = 1'b0;
        end
        if (collecting) begin
          word[idx] = tx_bit;
          holdOk    = holdOk && load_ack && busy && !rcv_ack;
          idx++;
          if (idx == N) begin
            collecting  = 1'b0;
            postPending = 1'b1;
            checkOutput("holdDuringSend", holdOk, 1);
            checksTotal++;
            if (expQ.size() == 0) begin
              $display("[TB] FAIL wordMatch: unexpected transfer, got %h, expected none", word);
            end else begin
              exp = expQ.pop_front();
              if (word === exp) checksPassed++;
              else $display("[TB] FAIL wordMatch: got %h, expected %h", word, exp);
            end
          end
        end else if (rcv_ack) begin
          collecting = 1'b1;
          idx        = 0;
          holdOk     = 1'b1;
          word       = '0;
        end
      end
    end
  end

  // Hard stop in case the design never releases the bench.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : driver
    logic [N-1:0] img;
    logic [N-1:0] img2;
    bit           ok;

    // Reset held with both requests high: everything stays quiet, then the
    // first edge after release captures the image.
    #1;
    xrst     = 1'b1;
    img      = randImg();
    img[7:0] = 8'hA5;
    image_in = img;
    load_req = 1'b1;
    rcv_req  = 1'b1;
    ok       = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ok = ok && !load_ack && !rcv_ack && !tx_bit && !busy;
    end
    checkOutput("resetHold", ok, 1);
    xrst = 1'b0;
    applyStimulus(img, 0, 1'b1, 1'b0, '0);

    // Receiver not ready for 50 cycles.
    applyStimulus(randImg(), 50, 1'b0, 1'b0, '0);

    // Boundary patterns.
    applyStimulus({N{1'b1}}, int'($urandom_range(0, 4)), 1'b0, 1'b0, '0);
    applyStimulus({N{1'b0}}, int'($urandom_range(0, 4)), 1'b0, 1'b0, '0);
    img = '0;
    img[N-1] = 1'b1;
    applyStimulus(img, int'($urandom_range(0, 4)), 1'b0, 1'b0, '0);

    // Back-to-back: load_req held through the end of the first transfer.
    img  = randImg();
    img2 = randImg();
    applyStimulus(img, 1, 1'b0, 1'b1, img2);
    applyStimulus(img2, 3, 1'b1, 1'b0, '0);

    // Reset in the middle of the send phase.
    img = randImg();
    @(negedge clk);
    image_in = img;
    load_req = 1'b1;
    @(negedge clk);
    checkOutput("midCapture", load_ack, 1);
    expQ.push_back(img);
    load_req = 1'b0;
    rcv_req  = 1'b1;
    @(negedge clk);
    checkOutput("midAck", rcv_ack, 1);
    rcv_req = 1'b0;
    repeat (400) @(negedge clk);
    #2;
    resetAbort = 1'b1;
    xrst       = 1'b1;
    #1;
    checkOutput("asyncReset", {28'd0, tx_bit, busy, load_ack, rcv_ack}, 0);
    @(negedge clk);
    @(negedge clk);
    xrst = 1'b0;
    ok   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok = ok && !busy && !load_ack && !tx_bit;
    end
    checkOutput("idleAfterReset", ok, 1);
    applyStimulus(randImg(), 2, 1'b0, 1'b0, '0);

    // A few fully random transfers.
    for (int t = 0; t < 3; t++) begin
      applyStimulus(randImg(), int'($urandom_range(0, 20)), 1'b0, 1'b0, '0);
    end

    repeat (5) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
